// File: rtl/common_pkg.sv
// Shared scalar types for the pipeline: machine word, ALU and mul/div opcodes,
// and the divider state encoding.
package common_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_t;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/pipes_pkg.sv
// Inter-stage bundles around the execute stage: decode-to-execute input and
// execute-to-memory output.
package pipes_pkg;
  import common_pkg::*;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_src_imm;   // operand B is the extended immediate
    logic       imm_zext;      // zero-extend instead of sign-extend
    logic       shift_var;     // shift amount from rs_word[4:0]
    md_op_t     md_op;
    logic       mem_to_reg;
    logic       reg_dst;
  } ctrl_t;

  typedef struct packed {
    word_t       pc;
    word_t       pc_plus_4;
    word_t       instruction;
    ctrl_t       control;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    word_t       rs_word;
    word_t       rt_word;
    logic [15:0] imm;
  } d_e_reg_t;

  typedef struct packed {
    word_t      pc;
    word_t      pc_plus_4;
    word_t      instruction;
    logic       mem_to_reg;
    logic       reg_dst;
    word_t      alu_result;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    word_t      rs_word;
    word_t      rt_word;
  } e_m_reg_t;

endpackage

// File: rtl/muldiv.sv
// HI/LO owner with a single-cycle multiplier; the iterative restoring divider
// is built only when MIPS_DIV_EN is defined, otherwise DIV/DIVU are no-ops.
module muldiv
  import common_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   start,
  input  md_op_t md_op,
  input  word_t  a,
  input  word_t  b,
  output word_t  hi,
  output word_t  lo,
  output logic   busy
);

  word_t       hi_r, lo_r;
  logic [63:0] prod_s_s, prod_u_s;
  logic        div_wr_s;
  word_t       div_hi_s, div_lo_s;

  assign prod_s_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u_s = {32'd0, a} * {32'd0, b};

`ifdef MIPS_DIV_EN
  div_state_t  state_r, state_nxt_s;
  logic [4:0]  cnt_r;
  word_t       quo_r, rem_r, dvs_r;
  logic        done_r;
  logic        is_div_s, a_neg_s, b_neg_s, ge_s;
  word_t       a_mag_s, b_mag_s, rem_sub_s;
  logic [32:0] rem_sh_s;

  assign is_div_s  = start && ((md_op == MD_DIV) || (md_op == MD_DIVU));
  assign a_neg_s   = (md_op == MD_DIV) && a[31];
  assign b_neg_s   = (md_op == MD_DIV) && b[31];
  assign a_mag_s   = a_neg_s ? (32'd0 - a) : a;
  assign b_mag_s   = b_neg_s ? (32'd0 - b) : b;
  assign rem_sh_s  = {rem_r, quo_r[31]};
  assign rem_sub_s = rem_sh_s[31:0] - dvs_r;
  assign ge_s      = (rem_sh_s >= {1'b0, dvs_r});
  // done_r lets the finished DIV, still held in the input register, leave without restarting.
  assign busy      = (state_r != S_IDLE) || (is_div_s && !done_r);
  assign div_wr_s  = (state_r == S_DONE);

  // Sign fix-up of the magnitudes; operands are still held upstream while busy.
  always_comb begin
    if (b == 32'd0) begin
      div_hi_s = a;
      div_lo_s = 32'hFFFF_FFFF;
    end else begin
      div_hi_s = a_neg_s ? (32'd0 - rem_r) : rem_r;
      div_lo_s = (a_neg_s ^ b_neg_s) ? (32'd0 - quo_r) : quo_r;
    end
  end

  // Divider next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  state_nxt_s = (is_div_s && !done_r) ? S_DIV : S_IDLE;
      S_DIV:   state_nxt_s = (cnt_r == 5'd31) ? S_DONE : S_DIV;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Divider state, iteration counter and shift registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
      cnt_r   <= 5'd0;
      quo_r   <= 32'd0;
      rem_r   <= 32'd0;
      dvs_r   <= 32'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_r == S_DONE);
      if ((state_r == S_IDLE) && is_div_s && !done_r) begin
        quo_r <= a_mag_s;
        rem_r <= 32'd0;
        dvs_r <= b_mag_s;
        cnt_r <= 5'd0;
      end else if (state_r == S_DIV) begin
        quo_r <= {quo_r[30:0], ge_s};
        rem_r <= ge_s ? rem_sub_s : rem_sh_s[31:0];
        cnt_r <= cnt_r + 5'd1;
      end
    end
  end
`else
  assign busy     = 1'b0;
  assign div_wr_s = 1'b0;
  assign div_hi_s = 32'd0;
  assign div_lo_s = 32'd0;
`endif

  // HI/LO write port: divider completion, multiply, or move-to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (div_wr_s) begin
      hi_r <= div_hi_s;
      lo_r <= div_lo_s;
    end else if (start) begin
      case (md_op)
        MD_MULT:  begin hi_r <= prod_s_s[63:32]; lo_r <= prod_s_s[31:0]; end
        MD_MULTU: begin hi_r <= prod_u_s[63:32]; lo_r <= prod_u_s[31:0]; end
        MD_MTHI:  hi_r <= a;
        MD_MTLO:  lo_r <= a;
        default:  begin hi_r <= hi_r; lo_r <= lo_r; end
      endcase
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/execute.sv
// Execute stage: input register, ALU and execute-to-memory assembly around muldiv.
// Define MIPS_DIV_EN to build the iterative divider; otherwise DIV/DIVU are single-cycle no-ops.
module execute
  import common_pkg::*;
  import pipes_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
)(
  input  logic     clk,
  input  logic     resetn,
  input  d_e_reg_t d_e_reg,
  input  logic     in_valid,
  output logic     in_ready,
  output e_m_reg_t e_m_reg,
  output logic     out_valid
);

  if (DIV_CYCLES != 32'd32) begin : g_div_cycles_unsupported
    $error("execute: only DIV_CYCLES = 32 is supported");
  end

  d_e_reg_t   q_r;
  logic       valid_r;
  logic       busy_s;
  word_t      hi_s, lo_s, imm_ext_s, op_b_s, alu_s, result_s;
  logic [4:0] shamt_s;

  // Input register; holds its contents while the divider stalls the stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_r     <= '0;
      valid_r <= 1'b0;
    end else if (in_ready) begin
      q_r     <= d_e_reg;
      valid_r <= in_valid;
    end
  end

  assign imm_ext_s = q_r.control.imm_zext ? {16'd0, q_r.imm} : {{16{q_r.imm[15]}}, q_r.imm};
  assign op_b_s    = q_r.control.alu_src_imm ? imm_ext_s : q_r.rt_word;
  assign shamt_s   = q_r.control.shift_var ? q_r.rs_word[4:0] : q_r.instruction[10:6];

  // ALU on the captured instruction.
  always_comb begin
    alu_s = 32'd0;
    case (q_r.control.alu_op)
      ALU_ADD:  alu_s = q_r.rs_word + op_b_s;
      ALU_SUB:  alu_s = q_r.rs_word - op_b_s;
      ALU_AND:  alu_s = q_r.rs_word & op_b_s;
      ALU_OR:   alu_s = q_r.rs_word | op_b_s;
      ALU_XOR:  alu_s = q_r.rs_word ^ op_b_s;
      ALU_NOR:  alu_s = ~(q_r.rs_word | op_b_s);
      ALU_SLT:  alu_s = {31'd0, ($signed(q_r.rs_word) < $signed(op_b_s))};
      ALU_SLTU: alu_s = {31'd0, (q_r.rs_word < op_b_s)};
      ALU_SLL:  alu_s = q_r.rt_word << shamt_s;
      ALU_SRL:  alu_s = q_r.rt_word >> shamt_s;
      ALU_SRA:  alu_s = $signed(q_r.rt_word) >>> shamt_s;
      ALU_LUI:  alu_s = {q_r.imm, 16'd0};
      default:  alu_s = 32'd0;
    endcase
  end

  // Mul/div ops report HI/LO for the move-from forms and zero otherwise.
  always_comb begin
    result_s = 32'd0;
    case (q_r.control.md_op)
      MD_NONE: result_s = alu_s;
      MD_MFHI: result_s = hi_s;
      MD_MFLO: result_s = lo_s;
      default: result_s = 32'd0;
    endcase
  end

  muldiv u_muldiv (
    .clk    (clk),
    .resetn (resetn),
    .start  (valid_r),
    .md_op  (q_r.control.md_op),
    .a      (q_r.rs_word),
    .b      (q_r.rt_word),
    .hi     (hi_s),
    .lo     (lo_s),
    .busy   (busy_s)
  );

  assign in_ready  = !busy_s;
  assign out_valid = valid_r && !busy_s;

  // Execute-to-memory bundle assembly.
  always_comb begin
    e_m_reg             = '0;
    e_m_reg.pc          = q_r.pc;
    e_m_reg.pc_plus_4   = q_r.pc_plus_4;
    e_m_reg.instruction = q_r.instruction;
    e_m_reg.mem_to_reg  = q_r.control.mem_to_reg;
    e_m_reg.reg_dst     = q_r.control.reg_dst;
    e_m_reg.alu_result  = result_s;
    e_m_reg.rs          = q_r.rs;
    e_m_reg.rt          = q_r.rt;
    e_m_reg.rd          = q_r.rd;
    e_m_reg.rs_word     = q_r.rs_word;
    e_m_reg.rt_word     = q_r.rt_word;
  end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage; divider vectors apply when MIPS_DIV_EN is defined.
module tb_execute;
  import common_pkg::*;
  import pipes_pkg::*;

  logic     clk, resetn, in_valid, in_ready, out_valid;
  d_e_reg_t d_e_reg;
  e_m_reg_t e_m_reg;
  int       checks = 0;
  int       errors = 0;

  execute #(.DIV_CYCLES(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .d_e_reg   (d_e_reg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e_m_reg   (e_m_reg),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic d_e_reg_t mk(input alu_op_t op, input md_op_t md, input word_t rsw,
                                  input word_t rtw, input logic [15:0] imm, input logic src_imm,
                                  input logic zext, input logic svar, input logic [4:0] shamt);
    d_e_reg_t v;
    v = '0;
    v.pc                  = 32'h0040_0000;
    v.pc_plus_4           = 32'h0040_0004;
    v.instruction         = {21'd0, shamt, 6'd0};
    v.control.alu_op      = op;
    v.control.md_op       = md;
    v.control.alu_src_imm = src_imm;
    v.control.imm_zext    = zext;
    v.control.shift_var   = svar;
    v.rs      = 5'd1;
    v.rt      = 5'd2;
    v.rd      = 5'd3;
    v.rs_word = rsw;
    v.rt_word = rtw;
    v.imm     = imm;
    return v;
  endfunction

  // Present one input and sample 1 ns after the capturing edge.
  task automatic drive(input d_e_reg_t v, input logic vld);
    d_e_reg  = v;
    in_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic alu_case(input string tag, input d_e_reg_t v, input word_t exp);
    drive(v, 1'b1);
    check_eq(tag, e_m_reg.alu_result, exp);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

`ifdef MIPS_DIV_EN
  task automatic run_div(input string tag, input md_op_t md, input word_t a, input word_t b,
                         input word_t exp_lo, input word_t exp_hi);
    int low;
    int early;
    low   = 0;
    early = 0;
    drive(mk(ALU_ADD, md, a, b, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b1);
    d_e_reg  = mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    in_valid = 1'b1;
    while (!in_ready && low < 100) begin
      if (out_valid) early++;
      low++;
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_stall_cycles"}, low, 32'd34);
    check_eq({tag, "_valid_while_busy"}, early, 32'd0);
    check_eq({tag, "_done_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_done_alu"}, e_m_reg.alu_result, 32'd0);
    @(posedge clk);
    #1;
    check_eq({tag, "_lo"}, e_m_reg.alu_result, exp_lo);
    drive(mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b1);
    check_eq({tag, "_hi"}, e_m_reg.alu_result, exp_hi);
  endtask
`endif

  initial begin
    d_e_reg_t v;
    resetn   = 1'b0;
    in_valid = 1'b0;
    d_e_reg  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_em_zero", {31'd0, (e_m_reg == '0)}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    alu_case("addu", mk(ALU_ADD, MD_NONE, 32'h7FFF_FFFF, 32'h1, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'h8000_0000);
    check_eq("addu_ready", {31'd0, in_ready}, 32'd1);
    alu_case("sra", mk(ALU_SRA, MD_NONE, 32'd0, 32'h8000_0000, 16'd0, 1'b0, 1'b0, 1'b0, 5'd4), 32'hF800_0000);
    alu_case("sltu", mk(ALU_SLTU, MD_NONE, 32'hFFFF_FFFF, 32'h1, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'd0);
    alu_case("slt", mk(ALU_SLT, MD_NONE, 32'hFFFF_FFFF, 32'h1, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'd1);
    alu_case("subu", mk(ALU_SUB, MD_NONE, 32'd3, 32'd5, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'hFFFF_FFFE);
    alu_case("nor", mk(ALU_NOR, MD_NONE, 32'h0F0F_0000, 32'h0000_00F0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'hF0F0_FF0F);
    alu_case("addiu_sext", mk(ALU_ADD, MD_NONE, 32'h100, 32'd0, 16'hFFFC, 1'b1, 1'b0, 1'b0, 5'd0), 32'h0000_00FC);
    alu_case("ori_zext", mk(ALU_OR, MD_NONE, 32'h1, 32'd0, 16'h8000, 1'b1, 1'b1, 1'b0, 5'd0), 32'h0000_8001);
    alu_case("lui", mk(ALU_LUI, MD_NONE, 32'd0, 32'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 5'd0), 32'h1234_0000);
    alu_case("sllv", mk(ALU_SLL, MD_NONE, 32'h24, 32'h1, 16'd0, 1'b0, 1'b0, 1'b1, 5'd9), 32'h10);
    alu_case("srl", mk(ALU_SRL, MD_NONE, 32'd0, 32'h8000_0000, 16'd0, 1'b0, 1'b0, 1'b0, 5'd31), 32'h1);

    v = mk(ALU_ADD, MD_NONE, 32'hCAFE_0000, 32'h0000_BEEF, 16'h0010, 1'b1, 1'b0, 1'b0, 5'd0);
    v.pc = 32'h1234_5678;
    v.control.mem_to_reg = 1'b1;
    alu_case("lw_addr", v, 32'hCAFE_0010);
    check_eq("pass_pc", e_m_reg.pc, 32'h1234_5678);
    check_eq("pass_rt_word", e_m_reg.rt_word, 32'h0000_BEEF);
    check_eq("pass_mem_to_reg", {31'd0, e_m_reg.mem_to_reg}, 32'd1);

    drive(mk(ALU_ADD, MD_NONE, 32'd1, 32'd1, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b0);
    check_eq("bubble_valid", {31'd0, out_valid}, 32'd0);

    drive(mk(ALU_ADD, MD_MULT, 32'hFFFF_FFFE, 32'd3, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b1);
    alu_case("mult_mfhi", mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'hFFFF_FFFF);
    alu_case("mult_mflo", mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'hFFFF_FFFA);
    drive(mk(ALU_ADD, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b1);
    alu_case("multu_mfhi", mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'h1);
    alu_case("multu_mflo", mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'hFFFF_FFFE);

    drive(mk(ALU_ADD, MD_MTHI, 32'h0000_0055, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b1);
    drive(mk(ALU_ADD, MD_MTLO, 32'h0000_0066, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b1);
    drive(mk(ALU_ADD, MD_MTHI, 32'hDEAD_DEAD, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b0);
    alu_case("mthi_bubble_hi", mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'h55);
    alu_case("mtlo_lo", mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'h66);

`ifdef MIPS_DIV_EN
    run_div("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu_5_0", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    run_div("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'hF);
`else
    drive(mk(ALU_ADD, MD_DIV, 32'd7, 32'd2, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b1);
    check_eq("div_noop_ready", {31'd0, in_ready}, 32'd1);
    check_eq("div_noop_valid", {31'd0, out_valid}, 32'd1);
    check_eq("div_noop_alu", e_m_reg.alu_result, 32'd0);
    alu_case("div_noop_lo", mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'h66);
    alu_case("div_noop_hi", mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'h55);
`endif

    drive(mk(ALU_ADD, MD_MTHI, 32'h11, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b1);
    drive(mk(ALU_ADD, MD_MTLO, 32'h22, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b1);
    drive(mk(ALU_ADD, MD_DIV, 32'd100, 32'd7, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 1'b1);
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b0;
    #1;
    check_eq("rst_div_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_div_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    alu_case("post_rst_addu", mk(ALU_ADD, MD_NONE, 32'd5, 32'd6, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'd11);
    alu_case("post_rst_hi", mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'd0);
    alu_case("post_rst_lo", mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
